ntt_ctrl: RTL
=============

# ntt_ctrl

Sequencer for the radix-2 NTT/INTT butterfly datapath. It runs all LOGN stages of an N-point transform over a dual-port coefficient memory and issues one butterfly per cycle. For each butterfly it produces the read address pair, the twiddle-table address and the butterfly mode select, then delays the address pair to match the butterfly pipeline so results are written back in place. The block sits between the top-level command interface and the butterfly, coefficient RAM and twiddle ROM.

## Interface
- N, 256, transform size; power of two, 4..32768.
- LOGN, 8, log2(N); address width of all address ports.
- BF_LATENCY, 3, cycles from rd_en to matching wr_en (RAM read + butterfly); ≥1.
- clk  in  1  single clock; all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  begin a transform; sampled only in IDLE.
- mode  in  1  0 = NTT (Cooley-Tukey), 1 = INTT (Gentleman-Sande); latched at start.
- busy  out  1  high from the first RUN cycle through the DONE cycle.
- done  out  1  one-cycle pulse in the DONE state.
- stage  out  4  current stage index 0..LOGN-1.
- rd_en  out  1  butterfly issue strobe.
- rd_addr_1, rd_addr_2  out  LOGN  operand addresses; 0 when rd_en=0.
- tw_addr  out  LOGN  twiddle ROM address; 0 when rd_en=0.
- tw_sel  out  1  latched mode; selects the forward or inverse twiddle table.
- bf_select  out  1  latched mode; drives the butterfly NTT/INTT select.
- wr_en  out  1  rd_en delayed by BF_LATENCY.
- wr_addr_1, wr_addr_2  out  LOGN  rd_addr_1/2 delayed by BF_LATENCY; 0 when wr_en=0.

## Operation
- FSM states: IDLE, RUN, DRAIN, DONE.
- IDLE: when start=1, latch mode, set stage=0 and k=0, then go to RUN.
- RUN: issue butterfly k with rd_en=1, then increment k. After k=N/2-1, clear k and go to DRAIN.
- DRAIN: hold for BF_LATENCY cycles with rd_en=0. Then:
  - if stage<LOGN-1, increment stage and return to RUN;
  - otherwise go to DONE.
- DONE: done=1 for one cycle, then go to IDLE.
- Butterfly span per stage:
  - NTT: len = N>>(stage+1).
  - INTT: len = 1<<stage.
  - Define l = log2(len).
- Address generation:
  - g = k>>l.
  - rd_addr_1 = (g<<(l+1)) | (k & (len-1)).
  - rd_addr_2 = rd_addr_1 + len.
  - tw_addr = (N>>(l+1)) + g, so tw_addr is always in 1..N-1.
- All arithmetic is unsigned LOGN-bit. No intermediate result exceeds N-1.
- start is ignored while busy=1. A new start is accepted in the cycle after DONE.
- bf_select and tw_sel hold the latched mode until the next accepted start. Reset value is 0.
- The write pipeline is a BF_LATENCY-deep shift register of {rd_en, rd_addr_1, rd_addr_2}. It shifts every cycle, including during DRAIN.

## Timing
- Reset values: state=IDLE, busy=0, done=0, stage=0, rd_en=0, wr_en=0, all addresses 0, tw_sel=0, bf_select=0, write pipeline cleared.
- Reset asserted mid-transform aborts immediately. No write strobes appear after rst_n rises.
- Cycle 0 is the edge where start is sampled. RUN occupies cycles 1..N/2, and butterfly k issues in cycle k+1.
- The last write of a stage coincides with the last DRAIN cycle. The next stage's first read is the following cycle, so there is no read-after-write hazard.
- done is asserted in cycle LOGN·(N/2+BF_LATENCY)+1. busy is high for exactly LOGN·(N/2+BF_LATENCY)+1 cycles.
- No stall input. Throughput during RUN is one butterfly per cycle.

## Configuration
- NTT_CTRL_PERF_EN defined: adds output cycle_count (16 bits).
  - Cleared on the accepted start.
  - Increments every cycle busy=1, saturating at 0xFFFF.
  - Holds its value in IDLE. Reset value is 0.
- NTT_CTRL_PERF_EN undefined: the cycle_count port and its logic do not exist.

## Test plan
All scenarios use N=8, LOGN=3, BF_LATENCY=3 unless stated.
- NTT run, mode=0:
  - stage 0 issues (0,4),(1,5),(2,6),(3,7), all with tw_addr=1;
  - stage 1 issues (0,2) tw 2, (1,3) tw 2, (4,6) tw 3, (5,7) tw 3;
  - stage 2 issues (0,1) tw 4, (2,3) tw 5, (4,5) tw 6, (6,7) tw 7;
  - done pulses in cycle 22;
  - bf_select=0 throughout.
- INTT run, mode=1:
  - stage 0 issues (0,1) tw 4 … (6,7) tw 7;
  - stage 2 issues (0,4) … (3,7), all with tw 1;
  - bf_select=1 and tw_sel=1 throughout.
- Write alignment: every wr_en pulse occurs exactly 3 cycles after its rd_en with identical addresses. Exactly 12 write pulses per run. No rd_en occurs in the same cycle as a wr_en belonging to the previous stage.
- start pulsed at cycle 5 of a run and again in the DONE cycle: both ignored. A start in the cycle after DONE launches a new run with first rd_en one cycle later.
- rst_n low at cycle 9 of a run: all outputs return to reset values immediately and no wr_en appears afterwards. A start after release gives a full 22-cycle run.
- With NTT_CTRL_PERF_EN: cycle_count=22 after a run and held in IDLE. Next start clears it to 0. With N=256, BF_LATENCY=3 it reads 1049.

Source files
------------

// File: rtl/ntt_ctrl_if.sv
// Signal bundle between the NTT sequencer and its command, RAM and butterfly neighbours.
// master = command/datapath side, slave = ntt_ctrl.
interface ntt_ctrl_if #(
  parameter int LOGN = 8
);
  logic            start;
  logic            mode;
  logic            busy;
  logic            done;
  logic [3:0]      stage;
  logic            rd_en;
  logic [LOGN-1:0] rd_addr_1;
  logic [LOGN-1:0] rd_addr_2;
  logic [LOGN-1:0] tw_addr;
  logic            tw_sel;
  logic            bf_select;
  logic            wr_en;
  logic [LOGN-1:0] wr_addr_1;
  logic [LOGN-1:0] wr_addr_2;

  modport master (
    output start, mode,
    input  busy, done, stage, rd_en, rd_addr_1, rd_addr_2, tw_addr,
           tw_sel, bf_select, wr_en, wr_addr_1, wr_addr_2
  );

  modport slave (
    input  start, mode,
    output busy, done, stage, rd_en, rd_addr_1, rd_addr_2, tw_addr,
           tw_sel, bf_select, wr_en, wr_addr_1, wr_addr_2
  );
endinterface

// File: rtl/ntt_ctrl.sv
// Radix-2 NTT/INTT stage sequencer: one butterfly address set per cycle, writes delayed in place.
// Define NTT_CTRL_PERF_EN to add the 16-bit saturating cycle_count output.
module ntt_ctrl #(
  parameter int N          = 256,
  parameter int LOGN       = 8,
  parameter int BF_LATENCY = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  ntt_ctrl_if.slave   bus
`ifdef NTT_CTRL_PERF_EN
  ,
  output logic [15:0] cycle_count
`endif
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  typedef struct packed {
    logic [LOGN-1:0] a1;
    logic [LOGN-1:0] a2;
    logic [LOGN-1:0] tw;
  } addr_t;

  localparam int              DW         = (BF_LATENCY > 1) ? $clog2(BF_LATENCY) : 1;
  localparam logic [LOGN-1:0] K_LAST     = LOGN'(N / 2 - 1);
  localparam logic [3:0]      STAGE_LAST = 4'(LOGN - 1);
  localparam logic [DW-1:0]   DRAIN_LAST = DW'(BF_LATENCY - 1);

  // NTT spans shrink from N/2 down to 1, INTT spans grow from 1 up to N/2.
  function automatic addr_t calc_addr(input logic [3:0] stg, input logic [LOGN-1:0] k,
                                      input logic inv);
    logic [3:0]      l;
    logic [LOGN-1:0] len;
    logic [LOGN-1:0] g;
    addr_t           r;
    l    = inv ? stg : STAGE_LAST - stg;
    len  = LOGN'(1) << l;
    g    = k >> l;
    r.a1 = (g << (l + 4'd1)) | (k & (len - LOGN'(1)));
    r.a2 = r.a1 + len;
    r.tw = (LOGN'(1) << (STAGE_LAST - l)) + g;
    return r;
  endfunction

  state_t          state;
  logic [LOGN-1:0] k;
  logic [3:0]      stage;
  logic [DW-1:0]   drain_cnt;
  logic            mode_q;
  logic            busy_q;
  logic            done_q;
  logic            rd_en_q;
  addr_t           rd_q;

  logic [3:0]      iss_stage;
  logic [LOGN-1:0] iss_k;
  logic            iss_inv;
  addr_t           issue;

  // Addresses are registered, so compute the butterfly that the next cycle will issue.
  always_comb begin
    iss_stage = stage;
    iss_k     = k + LOGN'(1);
    iss_inv   = mode_q;
    case (state)
      IDLE: begin
        iss_stage = '0;
        iss_k     = '0;
        iss_inv   = bus.mode;
      end
      DRAIN: begin
        iss_stage = stage + 4'd1;
        iss_k     = '0;
      end
      default: ;
    endcase
    issue = calc_addr(iss_stage, iss_k, iss_inv);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      k         <= '0;
      stage     <= '0;
      drain_cnt <= '0;
      mode_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      rd_en_q   <= 1'b0;
      rd_q      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            state   <= RUN;
            mode_q  <= bus.mode;
            stage   <= '0;
            k       <= '0;
            busy_q  <= 1'b1;
            rd_en_q <= 1'b1;
            rd_q    <= issue;
          end
        end
        RUN: begin
          if (k == K_LAST) begin
            state     <= DRAIN;
            k         <= '0;
            drain_cnt <= '0;
            rd_en_q   <= 1'b0;
            rd_q      <= '0;
          end else begin
            k    <= k + LOGN'(1);
            rd_q <= issue;
          end
        end
        // Next stage reads only after the last write of this stage has landed.
        DRAIN: begin
          if (drain_cnt == DRAIN_LAST) begin
            if (stage == STAGE_LAST) begin
              state  <= DONE;
              done_q <= 1'b1;
            end else begin
              state   <= RUN;
              stage   <= stage + 4'd1;
              rd_en_q <= 1'b1;
              rd_q    <= issue;
            end
          end else begin
            drain_cnt <= drain_cnt + DW'(1);
          end
        end
        DONE: begin
          state  <= IDLE;
          done_q <= 1'b0;
          busy_q <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  logic [2*LOGN:0] wr_pipe [BF_LATENCY];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < BF_LATENCY; i++) wr_pipe[i] <= '0;
    end else begin
      wr_pipe[0] <= {rd_en_q, rd_q.a1, rd_q.a2};
      for (int i = 1; i < BF_LATENCY; i++) wr_pipe[i] <= wr_pipe[i-1];
    end
  end

`ifdef NTT_CTRL_PERF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cycle_count <= '0;
    end else if (state == IDLE && bus.start) begin
      cycle_count <= '0;
    end else if (busy_q && cycle_count != 16'hFFFF) begin
      cycle_count <= cycle_count + 16'd1;
    end
  end
`endif

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.stage     = stage;
  assign bus.rd_en     = rd_en_q;
  assign bus.rd_addr_1 = rd_q.a1;
  assign bus.rd_addr_2 = rd_q.a2;
  assign bus.tw_addr   = rd_q.tw;
  assign bus.tw_sel    = mode_q;
  assign bus.bf_select = mode_q;
  assign {bus.wr_en, bus.wr_addr_1, bus.wr_addr_2} = wr_pipe[BF_LATENCY-1];

endmodule
